// File: rtl/sockit_spi_pkg.sv
// Shared definitions for the sockit SPI master: IO mode encoding, queue control
// field layout and the deserializer collector state.
package sockit_spi_pkg;

  typedef enum logic [1:0] {
    IOM_3WIRE = 2'd0,
    IOM_SPI   = 2'd1,
    IOM_DUAL  = 2'd2,
    IOM_QUAD  = 2'd3
  } iom_e;

  localparam int unsigned QCI_NEW     = 3;
  localparam int unsigned QCI_LST     = 2;
  localparam int unsigned QCI_IOM_MSB = 1;
  localparam int unsigned QCI_IOM_LSB = 0;

  typedef struct packed {
    logic nw;
    logic lst;
    iom_e iom;
  } qci_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } des_state_e;

endpackage

// File: rtl/sockit_spi_des_lane.sv
// One deserializer lane: SDW-bit shift-free register with synchronous clear
// and a single indexed bit write per sample.
module sockit_spi_des_lane
  import sockit_spi_pkg::*;
#(
  parameter int unsigned SDW = 8,
  parameter int unsigned SDL = $clog2(SDW)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           wr_i,
  input  logic [SDL-1:0] idx_i,
  input  logic           bit_i,
  output logic [SDW-1:0] dat_o
);

  logic [SDW-1:0] dat_q, dat_d;

  always_comb begin
    dat_d = dat_q;
    if (clr_i) begin
      dat_d = '0;
    end else if (wr_i) begin
      dat_d[idx_i] = bit_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dat_q <= '0;
    else     dat_q <= dat_d;
  end

  assign dat_o = dat_q;

endmodule

// File: rtl/sockit_spi_des.sv
// SPI input deserializer: collects one segment of samples on four lanes and emits
// it as a queue packet. Define SOCKIT_SPI_DES_OBUF_EN for a second output buffer.
module sockit_spi_des
  import sockit_spi_pkg::*;
#(
  parameter int unsigned SDW = 8,
  parameter int unsigned SDL = $clog2(SDW),
  parameter int unsigned QCI = 4,
  parameter int unsigned QDW = 4*SDW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           seg_vld,
  input  logic [QCI-1:0] seg_ctl,
  input  logic [SDL:0]   seg_len,
  output logic           seg_rdy,
  input  logic           smp_vld,
  input  logic [3:0]     smp_io,
  output logic           smp_rdy,
  output logic           que_vld,
  output logic [QCI-1:0] que_ctl,
  output logic [QDW-1:0] que_dat,
  input  logic           que_rdy
);

  localparam int unsigned LANES = 4;
  localparam int unsigned CW    = SDL + 1;

  des_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, len_q, len_d;
  logic [QCI-1:0] ctl_q, ctl_d;
  logic [QDW-1:0] lane_dat;
  logic [SDL-1:0] idx;
  logic           seg_trn, smp_trn, smp_lst;
  logic           direct_ok, hold_exit;

  assign seg_trn = seg_vld & seg_rdy;
  assign smp_trn = smp_vld & smp_rdy;
  assign smp_lst = (cnt_q == len_q - CW'(1));
  // first sample lands at the lane MSB
  assign idx     = SDL'(SDW - 1) - cnt_q[SDL-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (seg_trn) state_d = ST_COLLECT;
      ST_COLLECT: if (smp_trn && smp_lst) state_d = direct_ok ? ST_IDLE : ST_HOLD;
      ST_HOLD:    if (hold_exit) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    seg_rdy = 1'b0;
    smp_rdy = 1'b0;
    case (state_q)
      ST_IDLE:    seg_rdy = 1'b1;
      ST_COLLECT: smp_rdy = 1'b1;
      default:    ;
    endcase
  end

  // descriptor latch and sample counter; out-of-range lengths mean a full segment
  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    ctl_d = ctl_q;
    if (seg_trn) begin
      cnt_d = '0;
      ctl_d = seg_ctl;
      len_d = (seg_len == '0 || seg_len > CW'(SDW)) ? CW'(SDW) : seg_len;
    end else if (smp_trn) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      len_q <= CW'(SDW);
      ctl_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
      ctl_q <= ctl_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sockit_spi_des_lane #(.SDW(SDW), .SDL(SDL)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr_i (seg_trn),
      .wr_i  (smp_trn),
      .idx_i (idx),
      .bit_i (smp_io[k]),
      .dat_o (lane_dat[k*SDW +: SDW])
    );
  end

`ifdef SOCKIT_SPI_DES_OBUF_EN
  logic           que_vld_q, que_vld_d;
  logic [QCI-1:0] que_ctl_q, que_ctl_d;
  logic [QDW-1:0] que_dat_q, que_dat_d;
  logic [QDW-1:0] pkt_c;
  logic [SDW-1:0] ln_c;
  logic           slot_free, pkt_ld;

  assign slot_free = ~que_vld_q | que_rdy;
  assign direct_ok = slot_free;
  assign hold_exit = slot_free;
  assign pkt_ld    = (smp_trn & smp_lst & slot_free) | ((state_q == ST_HOLD) & slot_free);

  // packet as it stands after this edge's sample write
  always_comb begin
    pkt_c = lane_dat;
    ln_c  = '0;
    for (int k = 0; k < LANES; k++) begin
      ln_c = lane_dat[k*SDW +: SDW];
      if (smp_trn) ln_c[idx] = smp_io[k];
      pkt_c[k*SDW +: SDW] = ln_c;
    end
  end

  always_comb begin
    que_vld_d = que_vld_q;
    que_ctl_d = que_ctl_q;
    que_dat_d = que_dat_q;
    if (pkt_ld) begin
      que_vld_d = 1'b1;
      que_ctl_d = ctl_q;
      que_dat_d = pkt_c;
    end else if (que_vld_q && que_rdy) begin
      que_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      que_vld_q <= 1'b0;
      que_ctl_q <= '0;
      que_dat_q <= '0;
    end else begin
      que_vld_q <= que_vld_d;
      que_ctl_q <= que_ctl_d;
      que_dat_q <= que_dat_d;
    end
  end

  assign que_vld = que_vld_q;
  assign que_ctl = que_ctl_q;
  assign que_dat = que_dat_q;
`else
  // collector registers are the output slot; HOLD is the valid packet
  assign direct_ok = 1'b0;
  assign hold_exit = que_rdy;
  assign que_vld   = (state_q == ST_HOLD);
  assign que_ctl   = ctl_q;
  assign que_dat   = lane_dat;
`endif

endmodule

// File: tb/tb_sockit_spi_des.sv
// Directed bench for sockit_spi_des; expectations follow SOCKIT_SPI_DES_OBUF_EN.
module tb_sockit_spi_des;

  localparam int unsigned SDW = 8;
  localparam int unsigned SDL = 3;
  localparam int unsigned QCI = 4;
  localparam int unsigned QDW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           seg_vld;
  logic [QCI-1:0] seg_ctl;
  logic [SDL:0]   seg_len;
  logic           seg_rdy;
  logic           smp_vld;
  logic [3:0]     smp_io;
  logic           smp_rdy;
  logic           que_vld;
  logic [QCI-1:0] que_ctl;
  logic [QDW-1:0] que_dat;
  logic           que_rdy;

  int n_run  = 0;
  int n_fail = 0;

  sockit_spi_des #(.SDW(SDW), .SDL(SDL), .QCI(QCI), .QDW(QDW)) dut (
    .clk     (clk),
    .rst     (rst),
    .seg_vld (seg_vld),
    .seg_ctl (seg_ctl),
    .seg_len (seg_len),
    .seg_rdy (seg_rdy),
    .smp_vld (smp_vld),
    .smp_io  (smp_io),
    .smp_rdy (smp_rdy),
    .que_vld (que_vld),
    .que_ctl (que_ctl),
    .que_dat (que_dat),
    .que_rdy (que_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_seg(input logic [3:0] ctl, input logic [3:0] len);
    int n = 0;
    seg_vld = 1'b1;
    seg_ctl = ctl;
    seg_len = len;
    while (!seg_rdy && n < 50) begin
      tick();
      n++;
    end
    if (!seg_rdy) chk("seg_accept_timeout", 64'd0, 64'd1);
    tick();
    seg_vld = 1'b0;
  endtask

  task automatic send_smp(input logic [3:0] io);
    int n = 0;
    smp_vld = 1'b1;
    smp_io  = io;
    while (!smp_rdy && n < 50) begin
      tick();
      n++;
    end
    if (!smp_rdy) chk("smp_accept_timeout", 64'd0, 64'd1);
    tick();
    smp_vld = 1'b0;
  endtask

  // ios holds up to eight samples, first sample in the top nibble
  task automatic run_seg(input logic [3:0] ctl, input logic [3:0] len, input int n,
                         input logic [31:0] ios);
    send_seg(ctl, len);
    for (int i = 0; i < n; i++) send_smp(4'(ios >> (28 - 4*i)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; seg_vld = 1'b0; seg_ctl = '0; seg_len = '0;
    smp_vld = 1'b0; smp_io = '0; que_rdy = 1'b1;
    tick(); tick();
    chk("rst_seg_rdy", 64'(seg_rdy), 64'd1);
    chk("rst_smp_rdy", 64'(smp_rdy), 64'd0);
    chk("rst_que_vld", 64'(que_vld), 64'd0);
    chk("rst_que_dat", 64'(que_dat), 64'd0);
    rst = 1'b0;
    tick();

    // quad alternating pattern
    run_seg(4'hB, 4'd8, 8, 32'hF0F0F0F0);
    chk("quad_vld", 64'(que_vld), 64'd1);
    chk("quad_ctl", 64'(que_ctl), 64'hB);
    chk("quad_dat", 64'(que_dat), 64'hAAAAAAAA);
`ifdef SOCKIT_SPI_DES_OBUF_EN
    chk("quad_seg_rdy", 64'(seg_rdy), 64'd1);
`else
    chk("quad_seg_rdy", 64'(seg_rdy), 64'd0);
`endif
    tick();
    chk("quad_vld_fall", 64'(que_vld), 64'd0);

    // single-lane SPI on io[1]
    run_seg(4'h9, 4'd8, 8, 32'h20220020);
    chk("spi_ctl", 64'(que_ctl), 64'h9);
    chk("spi_dat", 64'(que_dat), 64'h0000B200);
    tick();

    // short segment
    run_seg(4'h4, 4'd3, 3, 32'h11100000);
    chk("short_vld", 64'(que_vld), 64'd1);
    chk("short_ctl", 64'(que_ctl), 64'h4);
    chk("short_dat", 64'(que_dat), 64'h000000E0);
    tick();

    // len 0 and len > SDW both mean a full segment
    run_seg(4'h3, 4'd0, 8, 32'h12481248);
    chk("len0_dat", 64'(que_dat), 64'h11224488);
    tick();
    run_seg(4'h3, 4'd15, 8, 32'h12481248);
    chk("len15_dat", 64'(que_dat), 64'h11224488);
    tick();

    // reset in the middle of a segment
    run_seg(4'hB, 4'd8, 4, 32'hFFFF0000);
    chk("mid_smp_rdy", 64'(smp_rdy), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_seg_rdy", 64'(seg_rdy), 64'd1);
    chk("arst_smp_rdy", 64'(smp_rdy), 64'd0);
    chk("arst_que_vld", 64'(que_vld), 64'd0);
    chk("arst_que_ctl", 64'(que_ctl), 64'd0);
    chk("arst_que_dat", 64'(que_dat), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_no_pkt", 64'(que_vld), 64'd0);
    run_seg(4'h3, 4'd8, 8, 32'h00000001);
    chk("post_rst_ctl", 64'(que_ctl), 64'h3);
    chk("post_rst_dat", 64'(que_dat), 64'h00000001);
    tick();

    // backpressure with two quad segments
    que_rdy = 1'b0;
    run_seg(4'hB, 4'd8, 8, 32'hFFFFFFFF);
    chk("bp_a_vld", 64'(que_vld), 64'd1);
    chk("bp_a_dat", 64'(que_dat), 64'hFFFFFFFF);
`ifdef SOCKIT_SPI_DES_OBUF_EN
    run_seg(4'h7, 4'd8, 8, 32'h0F0F0F0F);
    chk("bp_hold_smp_rdy", 64'(smp_rdy), 64'd0);
    chk("bp_hold_seg_rdy", 64'(seg_rdy), 64'd0);
    chk("bp_hold_dat", 64'(que_dat), 64'hFFFFFFFF);
    que_rdy = 1'b1;
    tick();
    chk("bp_b_vld", 64'(que_vld), 64'd1);
    chk("bp_b_ctl", 64'(que_ctl), 64'h7);
    chk("bp_b_dat", 64'(que_dat), 64'h55555555);
    tick();
    chk("bp_b_fall", 64'(que_vld), 64'd0);
`else
    seg_vld = 1'b1; seg_ctl = 4'h7; seg_len = 4'd8;
    repeat (5) tick();
    chk("bp_blocked_seg_rdy", 64'(seg_rdy), 64'd0);
    chk("bp_blocked_vld", 64'(que_vld), 64'd1);
    chk("bp_blocked_dat", 64'(que_dat), 64'hFFFFFFFF);
    que_rdy = 1'b1;
    tick();
    chk("bp_release_vld", 64'(que_vld), 64'd0);
    chk("bp_release_seg_rdy", 64'(seg_rdy), 64'd1);
    run_seg(4'h7, 4'd8, 8, 32'h0F0F0F0F);
    chk("bp_b_ctl", 64'(que_ctl), 64'h7);
    chk("bp_b_dat", 64'(que_dat), 64'h55555555);
    tick();
    chk("bp_b_fall", 64'(que_vld), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sockit_spi_des.md
# sockit_spi_des

SPI input deserializer for the sockit SPI master. Samples the four SPI IO lines on handshaked sample strobes from the clock/cycle generator, collects one transfer segment per lane, and emits it as a queue-protocol packet (QCI control bits plus QDW = 4×SDW data bits). Sits directly upstream of the queue-to-command repackager. It produces the lane layout that stage expects: lane k in dat[(k+1)·SDW-1 -: SDW], first sample at the lane MSB.

## Interface
- SDW, 8, serial data register width (samples per lane per segment)
- SDL, $clog2(SDW), SDW logarithm
- QCI, 4, queue control width: [3] new, [2] lst, [1:0] iom
- QDW, 4*SDW, queue data width
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- seg_vld  input  1  segment descriptor valid
- seg_ctl  input  QCI  segment control, copied to que_ctl
- seg_len  input  SDL+1  samples in segment, 1..SDW; 0 or >SDW treated as SDW
- seg_rdy  output  1  descriptor accepted
- smp_vld  input  1  IO sample valid (SPI sample clock edge)
- smp_io  input  4  sampled IO lines [3:0]
- smp_rdy  output  1  sample accepted; low stalls the SPI clock generator
- que_vld  output  1  queue packet valid
- que_ctl  output  QCI  queue control
- que_dat  output  QDW  queue data
- que_rdy  input  1  queue packet accepted

## Operation
- Handshakes: a transfer occurs when vld & rdy on a rising clk edge. Sources hold data stable while vld & ~rdy.
- Collector FSM states:
  - IDLE: seg_rdy=1, smp_rdy=0. seg transfer clears all lane registers, latches seg_ctl and seg_len, resets the sample counter to 0, and moves to COLLECT.
  - COLLECT: seg_rdy=0, smp_rdy=1. Each sample transfer writes smp_io[k] into lane k bit SDW-1-cnt for all four lanes, independent of iom. Unused LSBs stay 0. The counter increments.
  - Last sample (cnt == len-1): if the output slot is free, the complete packet goes straight to the output stage and the FSM returns to IDLE. Otherwise the FSM enters HOLD.
  - HOLD: seg_rdy=0, smp_rdy=0. The packet moves to the output stage as soon as the slot frees, then the FSM returns to IDLE.
- Output slot is free when que_vld=0, or when que_vld & que_rdy in the same cycle.
- Counter is SDL+1 bits wide and never wraps: it is reset on each segment accept.
- Reset (including mid-segment or mid-HOLD) discards all partial and pending data immediately.
- Reset values: seg_rdy=1, smp_rdy=0, que_vld=0, que_ctl=0, que_dat=0, FSM=IDLE, cnt=0.

## Timing
- seg_rdy and smp_rdy are registered-state decodes with no combinational path from que_rdy.
- With a free slot, que_vld rises the cycle after the last sample transfer.
- Segment accept to first sample accept: minimum 1 cycle.
- Throughput: back-to-back segments reach one sample per cycle, with 1 idle cycle per segment for the descriptor handshake.
- que_vld falls the cycle after que_trn unless a new packet loads on that same edge.

## Configuration
- SOCKIT_SPI_DES_OBUF_EN defined: a separate output register forms a second buffer. The collector accepts the next segment while the previous packet waits on que_rdy. The slot-free rule applies as above.
- Not defined: the collector register drives que_dat and que_ctl directly, and que_vld equals (FSM==HOLD).
  - The last sample always enters HOLD.
  - que_trn returns the FSM to IDLE.
  - Latency (1 cycle after the last sample) is unchanged, but no new segment is accepted until que_trn.

## Structure
- Shared package sockit_spi_pkg holds:
  - iom enum (3WIRE=0, SPI=1, DUAL=2, QUAD=3)
  - queue control field indices (NEW=3, LST=2, IOM=1:0)
  - the collector FSM state typedef
- One natural sub-module, sockit_spi_des_lane, instantiated 4×. It contains the per-lane SDW-bit register with clear and indexed bit write.

## Test plan
- Quad (iom=3, len=8, ctl=4'hB): smp_io alternating 4'hF,4'h0 for 8 samples -> one packet, que_dat=32'hAAAAAAAA, que_ctl=4'hB, que_vld high 1 cycle after the last sample.
- SPI (iom=1, len=8): smp_io[1] sequence 1,0,1,1,0,0,1,0 with other lines 0 -> que_dat[15:8]=8'hB2 and all other bytes 8'h00.
- Short last segment (len=3, ctl=4'h4): smp_io=4'h1 ×3 -> que_dat[7:0]=8'hE0, que_ctl=4'h4.
- Backpressure (que_rdy=0, two quad segments of 8 samples):
  - With OBUF_EN: the second segment completes, then HOLD, smp_rdy=0 and seg_rdy=0. When que_rdy=1, both packets emerge in order on consecutive transfers.
  - Without OBUF_EN: the second seg_vld is not accepted until the first que_trn.
- seg_len=0 -> 8 samples collected, identical to len=8.
- rst pulse after 4 of 8 samples -> all outputs return to reset values and no packet is emitted. A fresh segment afterwards yields correct data with no residue from the aborted segment.
